// File: rtl/wb_host_pkg.sv
// Shared definitions for the Wishbone host initiator.
// Contents:
//   state_t         - controller states (IDLE, BUS, RESP)
//   TIMEOUT_DEFAULT - default number of bus cycles to wait for ack
//   RSP_ERR_DATA    - read-data value returned with writes and timeouts
package wb_host_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int RSP_ERR_DATA    = 0;

endpackage

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic-cycle initiator.
// A request taken on the valid/ready command port becomes one Wishbone
// cycle; its result (read data, or a timeout error) is returned on the
// valid/ready response port. Only one transaction is in flight at a time.
// Ports:
//   wb_clk_i, wb_rst_i          - clock, async active-high reset
//   req_valid/req_ready         - command handshake
//   req_we/adr/dat/sel          - command fields
//   rsp_valid/rsp_ready         - response handshake
//   rsp_dat/rsp_err             - read data (0 for writes/errors), timeout flag
//   m_wb_*                      - Wishbone master port
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_adr,
  input  logic [DW-1:0]   req_dat,
  input  logic [DW/8-1:0] req_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            m_wb_cyc_o,
  output logic            m_wb_stb_o,
  output logic            m_wb_we_o,
  output logic [AW-1:0]   m_wb_adr_o,
  output logic [DW-1:0]   m_wb_dat_o,
  output logic [DW/8-1:0] m_wb_sel_o,
  input  logic [DW-1:0]   m_wb_dat_i,
  input  logic            m_wb_ack_i
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic            we_reg;
  logic [AW-1:0]   adr_reg;
  logic [DW-1:0]   dat_reg;
  logic [SW-1:0]   sel_reg;
  logic [DW-1:0]   rsp_dat_reg;
  logic            rsp_err_reg;

  logic            req_fire;
  logic            ack_hit;
  logic            tmo_hit;

  assign req_fire = (state_reg == IDLE) && req_valid;
  assign ack_hit  = (state_reg == BUS) && m_wb_ack_i;
  // Ack in the final allowed cycle takes priority over the timeout.
  assign tmo_hit  = (state_reg == BUS) && !m_wb_ack_i && (cnt_reg == CNT_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = BUS;
      BUS:     if (ack_hit || tmo_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      adr_reg     <= '0;
      dat_reg     <= '0;
      sel_reg     <= '0;
      rsp_dat_reg <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      if (req_fire) begin
        we_reg  <= req_we;
        adr_reg <= req_adr;
        dat_reg <= req_dat;
        sel_reg <= req_sel;
        cnt_reg <= '0;
      end
      if (ack_hit) begin
        rsp_dat_reg <= we_reg ? DW'(RSP_ERR_DATA) : m_wb_dat_i;
        rsp_err_reg <= 1'b0;
      end else if (tmo_hit) begin
        rsp_dat_reg <= DW'(RSP_ERR_DATA);
        rsp_err_reg <= 1'b1;
      end else if ((state_reg == BUS) && (cnt_reg != CNT_MAX)) begin
        // Saturating: the counter never wraps back into a valid window.
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // Handshake and strobe decode straight from the state flops, so they
  // drop asynchronously with reset.
  assign req_ready  = (state_reg == IDLE);
  assign rsp_valid  = (state_reg == RESP);
  assign m_wb_cyc_o = (state_reg == BUS);
  assign m_wb_stb_o = (state_reg == BUS);
  assign m_wb_we_o  = we_reg;
  assign m_wb_adr_o = adr_reg;
  assign m_wb_dat_o = dat_reg;
  assign m_wb_sel_o = sel_reg;
  assign rsp_dat    = rsp_dat_reg;
  assign rsp_err    = rsp_err_reg;

endmodule

// File: doc/wb_host_master.md
# wb_host_master

Single-outstanding Wishbone classic-cycle initiator. It accepts one read or write request on a valid/ready command port, runs one cycle on its Wishbone master port, and returns read data or a timeout error on a valid/ready response port. It sits on the user side, in front of the existing Wishbone interconnect master port. This lets on-chip logic (a logic-analyzer command path, later a UART bridge) reach the SRAM and UART responders without the management SoC.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; select width is DW/8
- TIMEOUT, 255, bus cycles to wait for ack before aborting; legal range 1..65535

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  reset; asynchronous assert, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_we  in  1  1 = write, 0 = read
- req_adr  in  AW  byte address
- req_dat  in  DW  write data
- req_sel  in  DW/8  byte enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_dat  out  DW  read data; 0 for writes and errors
- rsp_err  out  1  1 = timeout abort
- m_wb_cyc_o  out  1  cycle
- m_wb_stb_o  out  1  strobe
- m_wb_we_o  out  1  write enable
- m_wb_adr_o  out  AW  address
- m_wb_dat_o  out  DW  write data
- m_wb_sel_o  out  DW/8  byte select
- m_wb_dat_i  in  DW  read data
- m_wb_ack_i  in  1  acknowledge

## Operation
- FSM states: IDLE, BUS, RESP. Reset state is IDLE.
- IDLE
  - req_ready=1.
  - On req_valid: latch we/adr/dat/sel into the output registers, clear the timeout counter, go to BUS.
- BUS
  - cyc=stb=1; we/adr/dat/sel hold stable; req_ready=0.
  - On sampled ack: capture m_wb_dat_i into rsp_dat (or 0 if we=1), set rsp_err=0, drop cyc/stb, go to RESP.
  - Else the counter increments. When counter == TIMEOUT-1 and no ack: drop cyc/stb, set rsp_dat=0, rsp_err=1, go to RESP.
- RESP
  - rsp_valid=1; rsp_dat and rsp_err hold stable.
  - On rsp_ready: go to IDLE.
  - No new request is accepted until the response is consumed.
- Simultaneous events:
  - Ack in the same cycle as timeout expiry: ack wins, rsp_err=0.
  - Ack outside BUS: ignored, no state change.
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps.
- Reset mid-operation: cyc/stb fall immediately (asynchronously), the FSM returns to IDLE, and any pending response is discarded.
- Reset values: req_ready=1 (while reset is released), rsp_valid=0, rsp_dat=0, rsp_err=0, cyc=stb=we=0, adr=dat=sel=0.

## Timing
- All outputs are registered. req_ready and rsp_valid are decoded directly from state flops.
- Request accepted at edge N → cyc/stb high during cycle N..N+1.
- Ack sampled high at edge N+k (k≥1) → cyc/stb low and rsp_valid high after edge N+k. Minimum request-to-response latency is 2 edges.
- Timeout: with no ack, stb stays high for exactly TIMEOUT cycles, then rsp_valid rises with rsp_err=1.
- Response consumed at edge M → req_ready=1 after M. A new request can be accepted at edge M+1.
- Throughput: at most one transaction per 3 cycles with a zero-wait responder and rsp_ready tied high.
- Pipelined stall is not supported; classic cycles only.

## Structure
- Package wb_host_pkg holds:
  - state enum {IDLE, BUS, RESP}
  - TIMEOUT_DEFAULT = 255
  - RSP_ERR_DATA = 0
- Single module, no sub-module; the timeout counter is inline.

## Test plan
- Write: req adr=0x0000_0010, dat=0xA5A5_1234, sel=0xF; responder acks after 2 cycles → one cyc/stb pulse 2 cycles long with we=1 and those values; rsp_valid, rsp_err=0, rsp_dat=0.
- Read: req adr=0x0000_0010 we=0; responder acks with 0xA5A5_1234 → rsp_dat=0xA5A5_1234, rsp_err=0. Hold rsp_ready low 5 cycles → rsp stays stable and req_ready stays 0.
- Timeout: TIMEOUT=8, responder never acks → stb high exactly 8 cycles, then rsp_err=1, rsp_dat=0, cyc=0.
- Ack on last cycle: TIMEOUT=8, ack in the 8th bus cycle with data 0x5555_AAAA → rsp_err=0, rsp_dat=0x5555_AAAA.
- Reset mid-BUS: assert wb_rst_i 3 cycles into a read → cyc/stb drop without a clock edge; after release req_ready=1, rsp_valid=0. A following write completes normally.
- Back-to-back: 4 requests with req_valid held and rsp_ready=1, zero-wait responder → 4 bus cycles, each spaced 3 clocks; responses in order with correct data.
